// File: rtl/btn_conditioner_if.sv
// Push-button and slide-switch bundle between the board pins and the conditioner.
// The master side drives the raw levels; the slave side returns the conditioned signals.
interface btn_conditioner_if #(
   parameter int OLD_SIZE = 16
);
   logic                btnc_raw;
   logic                btnac_raw;
   logic                btnl_raw;
   logic                btnr_raw;
   logic                btnd_raw;
   logic [OLD_SIZE-1:0] sw_raw;

   logic                btnc;
   logic                btnac;
   logic                btnl;
   logic                btnr;
   logic                btnd;
   logic [OLD_SIZE-1:0] sw;

   modport master (
      output btnc_raw, btnac_raw, btnl_raw, btnr_raw, btnd_raw, sw_raw,
      input  btnc, btnac, btnl, btnr, btnd, sw
   );

   modport slave (
      input  btnc_raw, btnac_raw, btnl_raw, btnr_raw, btnd_raw, sw_raw,
      output btnc, btnac, btnl, btnr, btnd, sw
   );
endinterface

// File: rtl/btn_conditioner.sv
// Synchronises bouncy buttons and switches, debounces each button independently,
// and turns the two action buttons (centre, all-clear) into single-cycle press pulses.
module btn_conditioner #(
   parameter int OLD_SIZE        = 16,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   btn_conditioner_if.slave  bus
);
   localparam int              NB       = 5;
   localparam int              CW       = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   // Button order: 0 centre, 1 all-clear, 2 left, 3 right, 4 down.
   logic [NB-1:0]       btn_raw;
   logic [NB-1:0]       btn_s1_reg;
   logic [NB-1:0]       btn_s2_reg;
   logic [OLD_SIZE-1:0] sw_s1_reg;
   logic [OLD_SIZE-1:0] sw_s2_reg;
   logic [NB-1:0]       stable;
   logic [NB-1:0]       stable_d;

   assign btn_raw = {bus.btnd_raw, bus.btnr_raw, bus.btnl_raw, bus.btnac_raw, bus.btnc_raw};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btn_s1_reg <= '0;
         btn_s2_reg <= '0;
         sw_s1_reg  <= '0;
         sw_s2_reg  <= '0;
      end else begin
         btn_s1_reg <= btn_raw;
         btn_s2_reg <= btn_s1_reg;
         sw_s1_reg  <= bus.sw_raw;
         sw_s2_reg  <= sw_s1_reg;
      end
   end

   for (genvar gi = 0; gi < NB; gi++) begin : g_deb
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          stable_reg;
      logic          stable_next;
      logic          stable_d_reg;

      // Any return to the stable value mid-count restarts the count from zero.
      always_comb begin
         cnt_next    = '0;
         stable_next = stable_reg;
         if (btn_s2_reg[gi] != stable_reg) begin
            if (cnt_reg == CNT_LAST) begin
               stable_next = btn_s2_reg[gi];
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            cnt_reg      <= '0;
            stable_reg   <= 1'b0;
            stable_d_reg <= 1'b0;
         end else begin
            cnt_reg      <= cnt_next;
            stable_reg   <= stable_next;
            stable_d_reg <= stable_reg;
         end
      end

      assign stable[gi]   = stable_reg;
      assign stable_d[gi] = stable_d_reg;
   end

   assign bus.btnc  = stable[0] & ~stable_d[0];
   assign bus.btnac = stable[1] & ~stable_d[1];
   assign bus.btnl  = stable[2];
   assign bus.btnr  = stable[3];
   assign bus.btnd  = stable[4];
   assign bus.sw    = sw_s2_reg;
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner at DEBOUNCE_CYCLES=4: reset, clean press, bounce,
// glitch rejection, switch latency, simultaneous presses and mid-count reset.
module tb_btn_conditioner;
   localparam int OLD_SIZE = 16;
   localparam int DC       = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   btn_conditioner_if #(.OLD_SIZE(OLD_SIZE)) bus ();

   btn_conditioner #(
      .OLD_SIZE        (OLD_SIZE),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [1:0] pulses;
   logic [2:0] levels;
   assign pulses = {bus.btnc, bus.btnac};
   assign levels = {bus.btnl, bus.btnr, bus.btnd};

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic all_raw(input logic v);
      bus.btnc_raw  = v;
      bus.btnac_raw = v;
      bus.btnl_raw  = v;
      bus.btnr_raw  = v;
      bus.btnd_raw  = v;
   endtask

   task automatic quiet_wait(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check_val($sformatf("%s_nopulse[%0d]", tag, i), pulses, 2'b00);
      end
   endtask

   initial begin
      // Reset with every raw input high
      rst_n = 1'b0;
      all_raw(1'b1);
      bus.sw_raw = '1;
      tick();
      tick();
      check_val("rst_pulses", pulses, 2'b00);
      check_val("rst_levels", levels, 3'b000);
      check_val("rst_sw", bus.sw, 16'h0000);
      rst_n = 1'b1;
      for (int i = 0; i <= 6; i++) begin
         tick();
         check_val($sformatf("rel_pulse[%0d]", i), pulses, (i == 5) ? 2'b11 : 2'b00);
         check_val($sformatf("rel_lvl[%0d]", i), levels, (i >= 5) ? 3'b111 : 3'b000);
         if (i <= 1) check_val($sformatf("rel_sw[%0d]", i), bus.sw, (i == 1) ? 16'hffff : 16'h0000);
      end
      $display("txn reset_release done");

      all_raw(1'b0);
      bus.sw_raw = '0;
      quiet_wait("release_all", 10);
      check_val("release_levels", levels, 3'b000);
      check_val("release_sw", bus.sw, 16'h0000);
      $display("txn release_all done");

      // Clean press held 20 cycles
      bus.btnc_raw = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check_val($sformatf("clean_btnc[%0d]", i), bus.btnc, (i == 5) ? 1'b1 : 1'b0);
      end
      bus.btnc_raw = 1'b0;
      quiet_wait("clean_rel", 8);
      $display("txn clean_press done");

      // Bounce 1,0,1,0 then held 1: final rise at step 4, pulse at step 9
      for (int i = 0; i < 16; i++) begin
         bus.btnc_raw = (i < 4) ? ((i % 2) == 0) : 1'b1;
         tick();
         check_val($sformatf("bounce_btnc[%0d]", i), bus.btnc, (i == 9) ? 1'b1 : 1'b0);
      end
      bus.btnc_raw = 1'b0;
      quiet_wait("bounce_rel", 8);
      $display("txn bounce done");

      // Glitch of 3 cycles is rejected
      for (int i = 0; i < 12; i++) begin
         bus.btnl_raw = (i < 3);
         tick();
         check_val($sformatf("glitch3_btnl[%0d]", i), bus.btnl, 1'b0);
      end
      // 4-cycle excursion is accepted for 4 cycles
      for (int i = 0; i < 14; i++) begin
         bus.btnl_raw = (i < 4);
         tick();
         check_val($sformatf("glitch4_btnl[%0d]", i), bus.btnl, (i >= 5 && i <= 8) ? 1'b1 : 1'b0);
      end
      $display("txn glitch done");

      // Switch path: two edges of latency, no debouncing
      bus.sw_raw = 16'h285a;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val($sformatf("sw_a[%0d]", i), bus.sw, (i >= 1) ? 16'h285a : 16'h0000);
      end
      bus.sw_raw = 16'ha5c3;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val($sformatf("sw_b[%0d]", i), bus.sw, (i >= 1) ? 16'ha5c3 : 16'h285a);
      end
      $display("txn switch done");

      // Simultaneous btnc and btnac presses
      bus.btnc_raw  = 1'b1;
      bus.btnac_raw = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         check_val($sformatf("simul[%0d]", i), pulses, (i == 5) ? 2'b11 : 2'b00);
      end
      bus.btnc_raw  = 1'b0;
      bus.btnac_raw = 1'b0;
      quiet_wait("simul_rel", 8);
      $display("txn simultaneous done");

      // Reset on the third counting edge of a btnac press
      bus.btnac_raw = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_val($sformatf("midrst_pre[%0d]", i), bus.btnac, 1'b0);
      end
      rst_n = 1'b0;
      tick();
      check_val("midrst_in_rst", pulses, 2'b00);
      tick();
      check_val("midrst_in_rst2", bus.btnac, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i <= 7; i++) begin
         tick();
         check_val($sformatf("midrst_post[%0d]", i), bus.btnac, (i == 5) ? 1'b1 : 1'b0);
      end
      bus.btnac_raw = 1'b0;
      $display("txn midcount_reset done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
